// File: rtl/up_down_counter.sv
// up_down_counter: BITS-wide wrap-around up/down counter with count enable
// and synchronous active-low reset; Q is driven straight from the register.
module up_down_counter #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            up,
    output logic [BITS-1:0] Q
);
    logic [BITS-1:0] count;
    // Truncation to BITS bits gives the modulo-2^BITS wrap in both directions
    always_ff @(posedge clk)
        if (!reset_n)
            count <= '0;
        else if (enable)
            count <= up ? count + 1'b1 : count - 1'b1;
    assign Q = count;
endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter: directed stimulus with a queued scoreboard checking
// 4-, 1- and 8-bit counters driven by the same inputs.
module tb_up_down_counter;
    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       up;
    logic [3:0] q4;
    logic [0:0] q1;
    logic [7:0] q8;

    typedef struct {
        logic [3:0] e4;
        logic       e1;
        logic [7:0] e8;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   assertions = 0;
    int   failures = 0;
    int   m1 = 0;
    int   m8 = 0;

    up_down_counter #(.BITS(4)) dut4 (.clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .Q(q4));
    up_down_counter #(.BITS(1)) dut1 (.clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .Q(q1));
    up_down_counter #(.BITS(8)) dut8 (.clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .Q(q8));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // One edge of stimulus; the 4-bit expectation is given by the caller,
    // the 1- and 8-bit ones come from modular reference counts.
    task automatic step(input logic r, input logic e, input logic u, input int x4);
        reset_n = r;
        enable  = e;
        up      = u;
        if (!r) begin
            m1 = 0;
            m8 = 0;
        end else if (e) begin
            m1 = 1 - m1;
            m8 = (m8 + (u ? 1 : 255)) % 256;
        end
        sb.push_back('{4'(x4), 1'(m1), 8'(m8)});
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("q4", 32'(q4), 32'(cur.e4));
            chk("q1", 32'(q1), 32'(cur.e1));
            chk("q8", 32'(q8), 32'(cur.e8));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        enable  = 0;
        up      = 0;
        #2;
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        for (int i = 1; i <= 15; i++) step(1, 1, 1, i);
        step(1, 0, 0, 15);
        step(1, 0, 1, 15);
        step(1, 1, 1, 0);
        step(1, 1, 0, 15);
        for (int i = 14; i >= 0; i--) step(1, 1, 0, i);
        for (int i = 1; i <= 5; i++) step(1, 1, 1, i);
        for (int i = 1; i <= 16; i++) step(1, 1, 1, (5 + i) % 16);
        step(1, 1, 1, 6);
        step(1, 1, 1, 7);
        step(1, 1, 1, 8);
        step(1, 1, 0, 7);
        step(1, 1, 1, 8);
        step(1, 1, 0, 7);
        step(1, 1, 1, 8);
        step(1, 1, 1, 9);
        step(0, 1, 1, 0);
        step(1, 1, 1, 1);
        step(1, 1, 1, 2);
        step(0, 1, 0, 0);
        step(1, 0, 1, 0);
        step(1, 1, 0, 15);
        repeat (2) @(posedge clk);
        #2;
        chk("drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
